// File: rtl/shield_pkg.sv
// ----------------------------------------------------------------------------
// shield_pkg: state encoding and default tuning for the shield meter.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package shield_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAISED = 3'd1,
    ST_DELAY  = 3'd2,
    ST_REGEN  = 3'd3,
    ST_BROKEN = 3'd4
  } shield_state_t;

  // Defaults shared with the player action and game/health logic.
  localparam int SHIELD_W_DEF      = 4;
  localparam int MAX_SHIELD_DEF    = 15;
  localparam int DRAIN_DEF         = 1;
  localparam int REGEN_STEP_DEF    = 1;
  localparam int HIT_COST_DEF      = 3;
  localparam int REGEN_DELAY_DEF   = 2;
  localparam int BREAK_LOCKOUT_DEF = 6;

endpackage

`default_nettype wire

// File: rtl/shield_countdown.sv
// ----------------------------------------------------------------------------
// shield_countdown: loadable down-counter flagging its final tick (count==1).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module shield_countdown #(
  parameter int CNT_W = 3
) (
  input  logic             slowed_shield_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/shield_controller.sv
// ----------------------------------------------------------------------------
// shield_controller: per-player shield meter sequencer and hit arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module shield_controller
  import shield_pkg::*;
#(
  parameter int SHIELD_W      = SHIELD_W_DEF,
  parameter int MAX_SHIELD    = MAX_SHIELD_DEF,
  parameter int DRAIN         = DRAIN_DEF,
  parameter int REGEN_STEP    = REGEN_STEP_DEF,
  parameter int HIT_COST      = HIT_COST_DEF,
  parameter int REGEN_DELAY   = REGEN_DELAY_DEF,
  parameter int BREAK_LOCKOUT = BREAK_LOCKOUT_DEF
) (
  input  logic                slowed_shield_clk,
  input  logic                reset,
  input  logic                shield_btn,
  input  logic                hit_req,
  output logic                hit_ack,
  output logic                hit_blocked,
  output logic [SHIELD_W-1:0] shield,
  output logic                shield_up,
  output logic                broken
);

  localparam int EXT_W   = SHIELD_W + 1;
  localparam int CNT_MAX = (REGEN_DELAY > BREAK_LOCKOUT) ? REGEN_DELAY : BREAK_LOCKOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [EXT_W-1:0]    DRAIN_X   = EXT_W'(DRAIN);
  localparam logic [EXT_W-1:0]    HIT_X     = EXT_W'(HIT_COST);
  localparam logic [EXT_W-1:0]    STEP_X    = EXT_W'(REGEN_STEP);
  localparam logic [EXT_W-1:0]    MAX_X     = EXT_W'(MAX_SHIELD);
  localparam logic [SHIELD_W-1:0] FULL      = SHIELD_W'(MAX_SHIELD);
  localparam logic [CNT_W-1:0]    DLY_INIT  = CNT_W'(REGEN_DELAY);
  localparam logic [CNT_W-1:0]    LOCK_INIT = CNT_W'(BREAK_LOCKOUT);

  shield_state_t state;
  logic          req_seen;
  logic          hit_accept;
  logic          can_raise;
  logic          drain_zero;
  logic          dly_load;
  logic          dly_en;
  logic          dly_expire;
  logic          lock_load;
  logic          lock_en;
  logic          lock_expire;

  logic [EXT_W-1:0]    shield_ext;
  logic [EXT_W-1:0]    cost;
  logic [EXT_W-1:0]    drained;
  logic [EXT_W-1:0]    regen_sum;
  logic [SHIELD_W-1:0] regened;

  assign hit_accept = hit_req & ~req_seen;
  assign can_raise  = shield_btn & (shield != '0);
  assign shield_ext = {1'b0, shield};

  // Drain and hit cost combine into one saturating subtraction.
  always_comb begin
    cost = '0;
    if (shield_btn) cost = cost + DRAIN_X;
    if (hit_accept) cost = cost + HIT_X;
  end

  assign drained    = (cost >= shield_ext) ? '0 : (shield_ext - cost);
  assign drain_zero = (drained == '0);
  assign regen_sum  = shield_ext + STEP_X;
  assign regened    = (regen_sum >= MAX_X) ? FULL : regen_sum[SHIELD_W-1:0];

  assign lock_load = (state == ST_RAISED) && drain_zero;
  assign lock_en   = (state == ST_BROKEN);
  assign dly_load  = (state == ST_RAISED) && !drain_zero && !shield_btn;
  assign dly_en    = (state == ST_DELAY) && !can_raise;

  shield_countdown #(.CNT_W(CNT_W)) u_dly (
    .slowed_shield_clk (slowed_shield_clk),
    .reset             (reset),
    .load              (dly_load),
    .value             (DLY_INIT),
    .en                (dly_en),
    .expire            (dly_expire)
  );

  shield_countdown #(.CNT_W(CNT_W)) u_lock (
    .slowed_shield_clk (slowed_shield_clk),
    .reset             (reset),
    .load              (lock_load),
    .value             (LOCK_INIT),
    .en                (lock_en),
    .expire            (lock_expire)
  );

  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shield      <= FULL;
      shield_up   <= 1'b0;
      broken      <= 1'b0;
      hit_ack     <= 1'b0;
      hit_blocked <= 1'b0;
      req_seen    <= 1'b0;
    end else begin
      // Blocking is judged on the current state, before any release transition.
      hit_ack     <= hit_accept;
      hit_blocked <= hit_accept && (state == ST_RAISED);
      if (!hit_req) begin
        req_seen <= 1'b0;
      end else if (hit_accept) begin
        req_seen <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (can_raise) begin
            state     <= ST_RAISED;
            shield_up <= 1'b1;
          end
        end
        ST_RAISED: begin
          shield <= drained[SHIELD_W-1:0];
          if (drain_zero) begin
            state     <= ST_BROKEN;
            shield_up <= 1'b0;
            broken    <= 1'b1;
          end else if (!shield_btn) begin
            state     <= (REGEN_DELAY == 0) ? ST_REGEN : ST_DELAY;
            shield_up <= 1'b0;
          end
        end
        ST_DELAY: begin
          if (can_raise) begin
            state     <= ST_RAISED;
            shield_up <= 1'b1;
          end else if (dly_expire) begin
            state <= ST_REGEN;
          end
        end
        ST_REGEN: begin
          if (can_raise) begin
            state     <= ST_RAISED;
            shield_up <= 1'b1;
          end else begin
            shield <= regened;
            if (regened == FULL) state <= ST_IDLE;
          end
        end
        ST_BROKEN: begin
          shield <= '0;
          if (lock_expire) begin
            state  <= ST_REGEN;
            broken <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          shield_up <= 1'b0;
          broken    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shield_controller.sv
// ----------------------------------------------------------------------------
// tb_shield_controller: directed and randomized checks against a phase model.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_shield_controller;

  localparam int MAXS = 15;
  localparam int DRN  = 1;
  localparam int STEP = 1;
  localparam int HITC = 3;
  localparam int RDLY = 2;
  localparam int LOCK = 6;

  localparam int P_IDLE = 0, P_RAISED = 1, P_DELAY = 2, P_REGEN = 3, P_BROKEN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shield_btn = 1'b0;
  logic       hit_req = 1'b0;
  logic       hit_ack;
  logic       hit_blocked;
  logic [3:0] shield;
  logic       shield_up;
  logic       broken;

  int checks = 0;
  int errors = 0;

  int m_phase = P_IDLE;
  int m_meter = MAXS;
  int m_wait  = 0;
  bit m_seen  = 1'b0;
  bit m_ack   = 1'b0;
  bit m_blk   = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  shield_controller dut (
    .slowed_shield_clk (clk),
    .reset             (reset),
    .shield_btn        (shield_btn),
    .hit_req           (hit_req),
    .hit_ack           (hit_ack),
    .hit_blocked       (hit_blocked),
    .shield            (shield),
    .shield_up         (shield_up),
    .broken            (broken)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase model: remaining-wait counts, integer meter arithmetic.
  task automatic model_step(input logic r, input logic b, input logic h);
    bit acc;
    int cost;
    if (r == 1'b0) begin
      m_phase = P_IDLE; m_meter = MAXS; m_wait = 0;
      m_seen = 0; m_ack = 0; m_blk = 0; m_valid = 1;
    end else begin
      acc   = h && !m_seen;
      m_ack = acc;
      m_blk = acc && (m_phase == P_RAISED);
      m_seen = h;
      case (m_phase)
        P_IDLE: if (b && m_meter > 0) m_phase = P_RAISED;
        P_RAISED: begin
          cost = (b ? DRN : 0) + (acc ? HITC : 0);
          m_meter = (m_meter > cost) ? m_meter - cost : 0;
          if (m_meter == 0) begin
            m_phase = P_BROKEN; m_wait = LOCK;
          end else if (!b) begin
            if (RDLY > 0) begin m_phase = P_DELAY; m_wait = RDLY; end
            else m_phase = P_REGEN;
          end
        end
        P_DELAY: begin
          if (b && m_meter > 0) m_phase = P_RAISED;
          else begin
            m_wait--;
            if (m_wait == 0) m_phase = P_REGEN;
          end
        end
        P_REGEN: begin
          if (b && m_meter > 0) m_phase = P_RAISED;
          else begin
            m_meter = (m_meter + STEP >= MAXS) ? MAXS : m_meter + STEP;
            if (m_meter == MAXS) m_phase = P_IDLE;
          end
        end
        default: begin
          m_meter = 0;
          m_wait--;
          if (m_wait == 0) m_phase = P_REGEN;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset, shield_btn, hit_req);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_shield", 32'(shield), 32'(m_meter));
      chk("model_shield_up", 32'(shield_up), 32'(m_phase == P_RAISED));
      chk("model_broken", 32'(broken), 32'(m_phase == P_BROKEN));
      chk("model_hit_ack", 32'(hit_ack), 32'(m_ack));
      if (m_ack) chk("model_hit_blocked", 32'(hit_blocked), 32'(m_blk));
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_shield", 32'(shield), 15);
    chk("rst_up", 32'(shield_up), 0);
    chk("rst_broken", 32'(broken), 0);
    chk("rst_ack", 32'(hit_ack), 0);

    // Raise, drain, then a blocked hit while held
    reset = 1'b1; tick();
    shield_btn = 1'b1; tick();
    chk("raise_up", 32'(shield_up), 1);
    chk("raise_shield", 32'(shield), 15);
    repeat (5) tick();
    chk("drain10", 32'(shield), 10);
    hit_req = 1'b1; tick();
    chk("hit_ack", 32'(hit_ack), 1);
    chk("hit_blocked", 32'(hit_blocked), 1);
    chk("hit_shield", 32'(shield), 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_ack", 32'(hit_ack), 0);
    end
    chk("held_shield", 32'(shield), 3);
    hit_req = 1'b0;
    repeat (3) tick();
    chk("break_flag", 32'(broken), 1);
    chk("break_shield", 32'(shield), 0);
    chk("break_up", 32'(shield_up), 0);

    // Lockout with button held, then regen and re-raise
    repeat (5) tick();
    chk("lock_still", 32'(broken), 1);
    tick();
    chk("lock_done", 32'(broken), 0);
    chk("lock_regen0", 32'(shield), 0);
    tick();
    chk("regen1", 32'(shield), 1);
    tick();
    chk("reraise_up", 32'(shield_up), 1);
    shield_btn = 1'b0;
    repeat (20) tick();
    chk("back_full", 32'(shield), 15);

    // Unblocked hit in IDLE, release, second hit
    hit_req = 1'b1; tick();
    chk("idle_ack", 32'(hit_ack), 1);
    chk("idle_blk", 32'(hit_blocked), 0);
    chk("idle_shield", 32'(shield), 15);
    tick();
    chk("idle_ack_pulse", 32'(hit_ack), 0);
    hit_req = 1'b0; tick();
    hit_req = 1'b1; tick();
    chk("idle_ack2", 32'(hit_ack), 1);
    hit_req = 1'b0; tick();

    // Release at 8: two frozen delay ticks, then regen to full
    shield_btn = 1'b1; tick();
    repeat (7) tick();
    chk("at8", 32'(shield), 8);
    shield_btn = 1'b0; tick();
    chk("dly_up", 32'(shield_up), 0);
    chk("dly_a", 32'(shield), 8);
    tick(); chk("dly_b", 32'(shield), 8);
    tick(); chk("dly_c", 32'(shield), 8);
    tick(); chk("regen9", 32'(shield), 9);
    repeat (6) tick();
    chk("regen_full", 32'(shield), 15);
    chk("regen_idle_up", 32'(shield_up), 0);

    // Re-press during DELAY
    shield_btn = 1'b1; tick();
    repeat (7) tick();
    shield_btn = 1'b0; tick();
    shield_btn = 1'b1; tick();
    chk("repress_up", 32'(shield_up), 1);
    chk("repress_shield", 32'(shield), 8);
    tick();
    chk("repress_drain", 32'(shield), 7);

    // Reset mid-BROKEN with a hit pending
    repeat (7) tick();
    chk("pre_rst_broken", 32'(broken), 1);
    reset = 1'b0; hit_req = 1'b1; shield_btn = 1'b0; tick();
    chk("rst_mid_shield", 32'(shield), 15);
    chk("rst_mid_broken", 32'(broken), 0);
    chk("rst_mid_ack", 32'(hit_ack), 0);
    reset = 1'b1; hit_req = 1'b0; tick();
    chk("post_rst_up", 32'(shield_up), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 8) shield_btn = ~shield_btn;
      if (!hit_req) hit_req = ($urandom_range(0, 99) < 15);
      else if ($urandom_range(0, 99) < 30) hit_req = 1'b0;
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
